// File: rtl/ahb3lite_mem_responder.sv
// AHB3-Lite single-port memory slave: word-indexed array, byte-lane writes,
// programmable wait states and a two-cycle ERROR response for bad accesses.
module ahb3lite_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    logic [31:0]   r_mem [DEPTH_WORDS];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_wait_cnt;
    logic [3:0]    w_wait_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic          r_write;
    logic          w_write_nxt;
    logic [3:0]    r_be;
    logic [3:0]    w_be_nxt;

    logic [31:0]   w_offset;
    logic          w_bad;
    logic          w_accept;
    logic          w_data_done;
    logic          w_readyout;
    logic          w_resp;
    logic [3:0]    w_be_acc;
    logic          w_unused;

    assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Offset wraps for addresses below BASE_ADDR, landing in the error range
    assign w_offset    = HADDR - BASE_ADDR;
    assign w_bad       = (w_offset >= MEM_BYTES)
                       | (HSIZE > 3'd2)
                       | ((HSIZE == 3'd1) & HADDR[0])
                       | ((HSIZE == 3'd2) & (|HADDR[1:0]));
    assign w_accept    = HSEL & HREADY & HTRANS[1] & w_readyout;
    assign w_data_done = (r_state == ST_DATA) && (r_wait_cnt == 4'd0);

    always_comb begin
        unique case (HSIZE[1:0])
            2'd0:    w_be_acc = 4'b0001 << w_offset[1:0];
            2'd1:    w_be_acc = w_offset[1] ? 4'b1100 : 4'b0011;
            default: w_be_acc = 4'b1111;
        endcase
    end

    // Next state and response outputs
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_idx_nxt   = r_idx;
        w_write_nxt = r_write;
        w_be_nxt    = r_be;
        w_readyout  = 1'b1;
        w_resp      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_DATA: begin
                w_readyout = (r_wait_cnt == 4'd0);
                if (r_wait_cnt != 4'd0) begin
                    w_wait_nxt = r_wait_cnt - 4'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: begin
                w_readyout  = 1'b0;
                w_resp      = 1'b1;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                w_resp      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            w_state_nxt = w_bad ? ST_ERR1 : ST_DATA;
            w_wait_nxt  = w_bad ? 4'd0 : WS_LOAD;
            w_idx_nxt   = w_offset[AW+1:2];
            w_write_nxt = HWRITE;
            w_be_nxt    = w_be_acc;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_be       <= 4'b0000;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_idx      <= w_idx_nxt;
            r_write    <= w_write_nxt;
            r_be       <= w_be_nxt;
        end
    end

    // Storage is deliberately not reset; reset forces IDLE so no write can commit
    always_ff @(posedge HCLK) begin
        if (w_data_done && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADYOUT = w_readyout;
    assign HRESP     = w_resp;
    assign HRDATA    = (w_data_done && !r_write) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_ahb3lite_mem_responder.sv
// Directed bench: three responders (0/3/2 wait states) on a shared bus,
// each selected individually; expected values are hand-computed constants.
module tb_ahb3lite_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata [3];
    logic [2:0]  hro;
    logic [2:0]  hresp;

    int n_checks = 0;
    int n_pass   = 0;

    ahb3lite_mem_responder #(.BASE_ADDR(32'h0000_1000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(hro[0]), .HRDATA(hrdata[0]), .HREADYOUT(hro[0]), .HRESP(hresp[0]));

    ahb3lite_mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(hro[1]), .HRDATA(hrdata[1]), .HREADYOUT(hro[1]), .HRESP(hresp[1]));

    ahb3lite_mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADY(hro[2]), .HRDATA(hrdata[2]), .HREADYOUT(hro[2]), .HRESP(hresp[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single non-pipelined transfer; entry and exit just after a rising edge
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic resp_first,
                        output logic resp_last, output int waits);
        sel[k] = 1'b1; haddr = addr; htrans = 2'd2; hwrite = wr; hsize = size;
        step();
        sel = 3'b000; htrans = 2'd0; hwdata = wdata;
        resp_first = hresp[k];
        waits = 0;
        while (hro[k] !== 1'b1 && waits < 32) begin
            step();
            waits++;
        end
        if (waits >= 32) begin
            n_checks++;
            $display("FAIL xfer_timeout: dut %0d addr %h never returned HREADYOUT=1", k, addr);
        end
        rdata     = hrdata[k];
        resp_last = hresp[k];
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 3'b000; haddr = '0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({hro[k], hresp[k], hrdata[k]} !== {1'b1, 1'b0, 32'h0})
                $display("FAIL reset_outputs dut%0d: got ready=%b resp=%b rdata=%h want 1 0 0", k, hro[k], hresp[k], hrdata[k]);
            else n_pass++;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        sel[0] = 1'b1; haddr = 32'h0000_1010; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
        step();
        n_checks++;
        if (hro[0] !== 1'b1 || hresp[0] !== 1'b0) $display("FAIL b2b_wr_phase: got ready=%b resp=%b want 1 0", hro[0], hresp[0]);
        else n_pass++;
        hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
        step();
        n_checks++;
        if ({hro[0], hresp[0], hrdata[0]} !== {1'b1, 1'b0, 32'hDEAD_BEEF})
            $display("FAIL b2b_rd_phase: got ready=%b resp=%b rdata=%h want 1 0 deadbeef", hro[0], hresp[0], hrdata[0]);
        else n_pass++;
        sel = 3'b000; htrans = 2'd0;
        step();
        n_checks++;
        if (hrdata[0] !== 32'h0 || hro[0] !== 1'b1) $display("FAIL b2b_idle: got rdata=%h ready=%b want 0 1", hrdata[0], hro[0]);
        else n_pass++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic r1, r2; int w;
        logic [31:0] a_wr [5] = '{32'h1010, 32'h1013, 32'h1010, 32'h1011, 32'h1FFC};
        logic [2:0]  s_wr [5] = '{3'd2, 3'd0, 3'd1, 3'd0, 3'd2};
        logic [31:0] d_wr [5] = '{32'h1122_3344, 32'hAA00_0000, 32'h0000_5566, 32'hFFFF_77FF, 32'h600D_F00D};
        logic [31:0] a_rd [5] = '{32'h1010, 32'h1010, 32'h1010, 32'h1010, 32'h1FFC};
        logic [31:0] e_rd [5] = '{32'h1122_3344, 32'hAA22_3344, 32'hAA22_5566, 32'hAA22_7766, 32'h600D_F00D};
        for (int i = 0; i < 5; i++) begin
            xfer(0, 1'b1, a_wr[i], s_wr[i], d_wr[i], rd, r1, r2, w);
            xfer(0, 1'b0, a_rd[i], 3'd2, 32'h0, rd, r1, r2, w);
            n_checks++;
            if (rd !== e_rd[i] || r2 !== 1'b0 || w !== 0)
                $display("FAIL lane_%0d: got rdata=%h resp=%b waits=%0d want %h 0 0", i, rd, r2, w, e_rd[i]);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic r1, r2; int w;
        logic [31:0] a_e [5] = '{32'h2000, 32'h1012, 32'h1011, 32'h1010, 32'h0FFC};
        logic [2:0]  s_e [5] = '{3'd2, 3'd2, 3'd1, 3'd3, 3'd2};
        for (int i = 0; i < 5; i++) begin
            xfer(0, (i == 1), a_e[i], s_e[i], 32'h0, rd, r1, r2, w);
            n_checks++;
            if ({r1, r2, rd} !== {1'b1, 1'b1, 32'h0} || w !== 1)
                $display("FAIL err_%0d: got resp=%b/%b waits=%0d rdata=%h want 1/1 1 0", i, r1, r2, w, rd);
            else n_pass++;
        end
        // New transfer offered in ERR1 is only taken on the edge ending ERR2
        sel[0] = 1'b1; haddr = 32'h0000_2000; htrans = 2'd2; hwrite = 1'b0; hsize = 3'd2;
        step();
        n_checks++;
        if (hro[0] !== 1'b0 || hresp[0] !== 1'b1) $display("FAIL err1_phase: got ready=%b resp=%b want 0 1", hro[0], hresp[0]);
        else n_pass++;
        haddr = 32'h0000_1010;
        step();
        n_checks++;
        if (hro[0] !== 1'b1 || hresp[0] !== 1'b1) $display("FAIL err2_phase: got ready=%b resp=%b want 1 1", hro[0], hresp[0]);
        else n_pass++;
        step();
        n_checks++;
        if ({hro[0], hresp[0], hrdata[0]} !== {1'b1, 1'b0, 32'hAA22_7766})
            $display("FAIL err2_pipelined: got ready=%b resp=%b rdata=%h want 1 0 aa227766", hro[0], hresp[0], hrdata[0]);
        else n_pass++;
        sel = 3'b000; htrans = 2'd0;
        step();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic r1, r2; int w; int n;
        xfer(1, 1'b1, 32'h20, 3'd2, 32'hCAFE_F00D, rd, r1, r2, w);
        xfer(1, 1'b1, 32'h24, 3'd2, 32'h0123_4567, rd, r1, r2, w);
        n_checks++;
        if (w !== 3 || r2 !== 1'b0) $display("FAIL ws3_write: got waits=%0d resp=%b want 3 0", w, r2);
        else n_pass++;
        sel[1] = 1'b1; haddr = 32'h20; htrans = 2'd2; hwrite = 1'b0; hsize = 3'd2;
        step();
        haddr = 32'h24; htrans = 2'd3;
        n = 0;
        while (hro[1] !== 1'b1 && n < 32) begin step(); n++; end
        n_checks++;
        if (n !== 3 || hrdata[1] !== 32'hCAFE_F00D || hresp[1] !== 1'b0)
            $display("FAIL ws3_rd0: got waits=%0d rdata=%h resp=%b want 3 cafef00d 0", n, hrdata[1], hresp[1]);
        else n_pass++;
        step();
        sel = 3'b000; htrans = 2'd0;
        n = 0;
        while (hro[1] !== 1'b1 && n < 32) begin step(); n++; end
        n_checks++;
        if (n !== 3 || hrdata[1] !== 32'h0123_4567)
            $display("FAIL ws3_rd1_seq: got waits=%0d rdata=%h want 3 01234567", n, hrdata[1]);
        else n_pass++;
        step();
        n_checks++;
        if (hro[1] !== 1'b1 || hrdata[1] !== 32'h0) $display("FAIL ws3_idle: got ready=%b rdata=%h want 1 0", hro[1], hrdata[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic r1, r2; int w;
        xfer(2, 1'b1, 32'h40, 3'd2, 32'h1357_9BDF, rd, r1, r2, w);
        sel[2] = 1'b1; haddr = 32'h40; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
        step();
        sel = 3'b000; htrans = 2'd0; hwdata = 32'hFFFF_FFFF;
        n_checks++;
        if (hro[2] !== 1'b0) $display("FAIL ws2_wait: got ready=%b want 0", hro[2]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hro[2], hresp[2], hrdata[2]} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL reset_async: got ready=%b resp=%b rdata=%h want 1 0 0", hro[2], hresp[2], hrdata[2]);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        xfer(2, 1'b0, 32'h40, 3'd2, 32'h0, rd, r1, r2, w);
        n_checks++;
        if (rd !== 32'h1357_9BDF || w !== 2) $display("FAIL reset_no_write: got rdata=%h waits=%0d want 13579bdf 2", rd, w);
        else n_pass++;
        xfer(0, 1'b0, 32'h1010, 3'd2, 32'h0, rd, r1, r2, w);
        n_checks++;
        if (rd !== 32'hAA22_7766) $display("FAIL mem_retained: got rdata=%h want aa227766", rd);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_errors();
        test_wait_states();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
